// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache, grouped in one bundle.
// The slave modport is the cache's view; master is the fetch unit plus memory controller.
interface icache_if;
    logic        rdy;
    logic        pc_valid;
    logic [31:0] pc;
    logic        flush;
    logic        inst_ready;
    logic [31:0] inst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;

    modport slave (
        input  rdy, pc_valid, pc, flush, mem_done, mem_data,
        output inst_ready, inst, mem_req, mem_addr
    );

    modport master (
        output rdy, pc_valid, pc, flush, mem_done, mem_data,
        input  inst_ready, inst, mem_req, mem_addr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache with whole-line refill from word 0 upwards.
// Hits answer one cycle after the request; misses answer one cycle after the last refill word.
module icache #(
    parameter int INDEX_BITS     = 6,
    parameter int LINE_WORDS_LOG = 2
) (
    input  logic   clk,
    input  logic   rst,
    icache_if.slave bus
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << LINE_WORDS_LOG;
    localparam int TAG_BITS = 32 - INDEX_BITS - LINE_WORDS_LOG - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_RESPOND,
        S_HOLD
    } state_t;

    state_t                       r_state;
    logic [LINES-1:0]             r_valid;
    logic [TAG_BITS-1:0]          r_tags [LINES];
    logic [31:0]                  r_data [LINES*WORDS];
    logic [TAG_BITS-1:0]          r_req_tag;
    logic [INDEX_BITS-1:0]        r_req_idx;
    logic [LINE_WORDS_LOG-1:0]    r_req_off;
    logic [LINE_WORDS_LOG-1:0]    r_cnt;
    logic                         r_drop;
    logic [31:0]                  r_reply;
    logic                         r_inst_ready;
    logic [31:0]                  r_inst;
    logic                         r_mem_req;
    logic [31:0]                  r_mem_addr;

    logic [TAG_BITS-1:0]          w_tag;
    logic [INDEX_BITS-1:0]        w_idx;
    logic [LINE_WORDS_LOG-1:0]    w_off;
    logic                         w_hit;
    logic [31:0]                  w_hit_word;
    logic [LINE_WORDS_LOG-1:0]    w_cnt_next;
    logic                         w_last;
    logic                         w_fill_we;
    logic [31:0]                  w_fill_word;
    logic                         w_unused_pc_lsb;

    assign w_off           = bus.pc[LINE_WORDS_LOG+1:2];
    assign w_idx           = bus.pc[LINE_WORDS_LOG+1+INDEX_BITS:LINE_WORDS_LOG+2];
    assign w_tag           = bus.pc[31:LINE_WORDS_LOG+2+INDEX_BITS];
    assign w_unused_pc_lsb = ^bus.pc[1:0];

    assign w_hit       = r_valid[w_idx] && (r_tags[w_idx] == w_tag);
    assign w_hit_word  = r_data[{w_idx, w_off}];
    assign w_cnt_next  = r_cnt + 1'b1;
    assign w_last      = &r_cnt;
    assign w_fill_we   = rst && bus.rdy && (r_state == S_REFILL) && bus.mem_done;
    // The requested word may be the one arriving on the completing edge itself.
    assign w_fill_word = (r_cnt == r_req_off) ? bus.mem_data : r_reply;

    assign bus.inst_ready = r_inst_ready;
    assign bus.inst       = r_inst;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_addr   = r_mem_addr;

    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_data[{r_req_idx, r_cnt}] <= bus.mem_data;
            if (w_last) begin
                r_tags[r_req_idx] <= r_req_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_req_tag    <= '0;
            r_req_idx    <= '0;
            r_req_off    <= '0;
            r_cnt        <= '0;
            r_drop       <= 1'b0;
            r_reply      <= '0;
            r_inst_ready <= 1'b0;
            r_inst       <= '0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
        end else if (bus.rdy) begin
            r_inst_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.pc_valid && !bus.flush) begin
                        r_req_tag <= w_tag;
                        r_req_idx <= w_idx;
                        r_req_off <= w_off;
                        if (w_hit) begin
                            r_inst_ready <= 1'b1;
                            r_inst       <= w_hit_word;
                            r_state      <= S_HOLD;
                        end else begin
                            r_cnt      <= '0;
                            r_drop     <= 1'b0;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= {w_tag, w_idx, {LINE_WORDS_LOG{1'b0}}, 2'b00};
                            r_state    <= S_REFILL;
                        end
                    end
                end
                S_REFILL: begin
                    // The memory handshake cannot be aborted; a flush only suppresses the reply.
                    if (bus.flush) begin
                        r_drop <= 1'b1;
                    end
                    if (bus.mem_done) begin
                        if (r_cnt == r_req_off) begin
                            r_reply <= bus.mem_data;
                        end
                        r_cnt      <= w_cnt_next;
                        r_mem_addr <= {r_req_tag, r_req_idx, w_cnt_next, 2'b00};
                        if (w_last) begin
                            r_valid[r_req_idx] <= 1'b1;
                            r_mem_req          <= 1'b0;
                            r_drop             <= 1'b0;
                            if (r_drop || bus.flush) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_inst_ready <= 1'b1;
                                r_inst       <= w_fill_word;
                                r_state      <= S_RESPOND;
                            end
                        end
                    end
                end
                S_RESPOND: begin
                    r_state <= bus.flush ? S_IDLE : S_HOLD;
                end
                S_HOLD: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_icache.sv
// Randomised scoreboard bench for icache: a line-level reference cache predicts hit/miss,
// reply data and refill address order; a monitor checks every DUT reply and memory beat.
module tb_icache;
    localparam int unsigned NLINES = 64;
    localparam int unsigned BUDGET = 300;

    typedef struct {
        logic [31:0] data;
        int unsigned nmem;
        int unsigned lat;
        int unsigned acc;
    } exp_t;

    logic clk;
    logic rst;
    icache_if bus ();

    icache #(
        .INDEX_BITS     (6),
        .LINE_WORDS_LOG (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned pend_mem = 0;
    int unsigned accepted = 0;
    bit          force_done = 1'b1;

    exp_t         exp_q[$];
    logic [31:0]  addr_q[$];
    logic [31:0]  mem_img [logic [31:0]];
    bit           m_valid [NLINES];
    int unsigned  m_tag   [NLINES];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: no response within %0d cycles (cycle %0d)", name, BUDGET, cyc);
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Memory controller: answers the presented address, with random gaps unless forced.
    initial begin
        bus.mem_done = 1'b0;
        bus.mem_data = '0;
        forever begin
            @(negedge clk);
            bus.mem_done = 1'b0;
            if (bus.mem_req === 1'b1 && (force_done || $urandom_range(0, 2) != 0)) begin
                bus.mem_done = 1'b1;
                bus.mem_data = rd(bus.mem_addr);
            end
        end
    end

    // Monitor: memory beats against the predicted address order, replies against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst && bus.rdy && bus.mem_req && bus.mem_done) begin
                accepted++;
                if (addr_q.size() == 0) chk("unexpected_mem_beat", bus.mem_addr, 32'hFFFF_FFFF);
                else chk("mem_addr", bus.mem_addr, addr_q.pop_front());
            end
            if (rst && bus.inst_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_inst_ready", bus.inst, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("inst", bus.inst, e.data);
                    chk("refill_beats", accepted, e.nmem);
                    if (e.lat != 0) chk("hit_latency", cyc - e.acc, e.lat);
                end
                accepted = 0;
            end
        end
    end

    // Reference model: plain line-number arithmetic over a tag/valid table.
    function automatic bit model_hit(input logic [31:0] a);
        int unsigned ln = a >> 4;
        return m_valid[ln % NLINES] && m_tag[ln % NLINES] == ln / NLINES;
    endfunction

    task automatic model_fill(input logic [31:0] a);
        int unsigned ln = a >> 4;
        m_valid[ln % NLINES] = 1'b1;
        m_tag[ln % NLINES]   = ln / NLINES;
        for (int unsigned k = 0; k < 4; k++) addr_q.push_back((ln << 4) + k * 4);
        pend_mem += 4;
    endtask

    task automatic issue(input logic [31:0] a, input bit expect_reply);
        exp_t e;
        bit   hit = model_hit(a);
        @(negedge clk);
        bus.pc_valid = 1'b1;
        bus.pc       = a | 32'($urandom_range(0, 3));
        if (!hit) model_fill(a);
        if (expect_reply) begin
            e.data = rd(a & ~32'h3);
            e.nmem = pend_mem;
            e.lat  = hit ? 1 : 0;
            e.acc  = cyc;
            pend_mem = 0;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_reply(input string name);
        int unsigned w;
        for (w = 0; w < BUDGET; w++) begin
            @(negedge clk);
            if (bus.inst_ready) break;
        end
        bus.pc_valid = 1'b0;
        if (w == BUDGET) timeout(name);
        @(negedge clk);
    endtask

    task automatic wait_addr(input logic [31:0] a, input string name);
        int unsigned w;
        for (w = 0; w < BUDGET; w++) begin
            @(negedge clk);
            if (bus.mem_addr == a && bus.mem_req) break;
        end
        if (w == BUDGET) timeout(name);
    endtask

    task automatic do_req(input logic [31:0] a);
        issue(a, 1'b1);
        wait_reply("reply");
    endtask

    task automatic do_flush_refill(input logic [31:0] a);
        int unsigned w;
        if (model_hit(a)) begin
            do_req(a);
        end else begin
            issue(a, 1'b0);
            wait_addr((a & ~32'hF) + 4, "flush_word1");
            bus.flush    = 1'b1;
            bus.pc_valid = 1'b0;
            @(negedge clk);
            bus.flush = 1'b0;
            for (w = 0; w < BUDGET; w++) begin
                @(negedge clk);
                if (!bus.mem_req) break;
            end
            if (w == BUDGET) timeout("flush_refill_end");
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic do_pause_refill(input logic [31:0] a);
        logic [31:0] held = (a & ~32'hF) + 4;
        issue(a, 1'b1);
        wait_addr(held, "pause_word1");
        bus.rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("pause_mem_addr", bus.mem_addr, held);
        chk("pause_mem_req", 32'(bus.mem_req), 32'd1);
        chk("pause_inst_ready", 32'(bus.inst_ready), 32'd0);
        bus.rdy = 1'b1;
        wait_reply("pause_reply");
    endtask

    initial begin
        int unsigned op;
        logic [31:0] a;
        for (int unsigned i = 0; i < NLINES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
        end
        mem_img[32'h1000] = 32'hA0;
        mem_img[32'h1004] = 32'hA1;
        mem_img[32'h1008] = 32'hA2;
        mem_img[32'h100C] = 32'hA3;
        rst          = 1'b0;
        bus.rdy      = 1'b1;
        bus.pc_valid = 1'b0;
        bus.pc       = '0;
        bus.flush    = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_inst_ready", 32'(bus.inst_ready), 32'd0);
        chk("reset_mem_req", 32'(bus.mem_req), 32'd0);
        chk("reset_mem_addr", bus.mem_addr, 32'd0);
        chk("reset_inst", bus.inst, 32'd0);
        rst = 1'b1;

        do_req(32'h0000);
        do_req(32'h1008);
        do_req(32'h100C);
        do_req(32'h2000);
        do_req(32'h0000);
        do_req(32'h0400);
        do_req(32'h0000);
        do_flush_refill(32'h3010);
        do_req(32'h3014);
        do_pause_refill(32'h4028);
        do_req(32'h402C);

        force_done = 1'b0;
        for (int unsigned n = 0; n < 120; n++) begin
            op = $urandom_range(0, 9);
            a  = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4)
               | (32'($urandom_range(0, 3)) << 2);
            if (op == 8) begin
                @(negedge clk);
                bus.pc_valid = 1'b1;
                bus.flush    = 1'b1;
                bus.pc       = a;
                @(negedge clk);
                bus.pc_valid = 1'b0;
                bus.flush    = 1'b0;
            end else if (op == 9) begin
                do_flush_refill(a | 32'h8000);
            end else begin
                do_req(a);
            end
        end

        repeat (4) @(negedge clk);
        chk("leftover_replies", 32'(exp_q.size()), 32'd0);
        chk("leftover_mem_beats", 32'(addr_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache answering the instruction-fetch unit's PC requests. Hits return the instruction word one cycle after the request is sampled. Misses refill a whole line from the memory controller over a word-wide request/done handshake, then return the requested word. Sits between the fetch stage and the memory controller; a flush input from branch/jump resolution discards any outstanding reply.

## Interface
- INDEX_BITS, 6, line index width (2^INDEX_BITS lines)
- LINE_WORDS_LOG, 2, log2 of 32-bit words per line (4 words = 16 B)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset (0 = reset)
- rdy  in  1  global ready; 0 freezes all state
- pc_valid  in  1  fetch request valid; held high by fetch until inst_ready seen
- pc  in  32  request address, word aligned; bits [1:0] ignored
- flush  in  1  jump/branch redirect; abandons any outstanding request
- inst_ready  out  1  one-cycle pulse: inst is the word at the accepted pc
- inst  out  32  returned instruction, valid when inst_ready=1
- mem_req  out  1  word read request to memory controller
- mem_addr  out  32  word-aligned read address
- mem_done  in  1  one-cycle pulse: mem_data holds the word at mem_addr
- mem_data  in  32  memory read data

## Operation
- Address split: offset = pc[LINE_WORDS_LOG+1:2]; index = pc[LINE_WORDS_LOG+1+INDEX_BITS : LINE_WORDS_LOG+2]; tag = the remaining upper bits. Per line: valid bit, tag, LINE_WORDS data words.
- States: IDLE, REFILL, RESPOND, HOLD.
- IDLE with pc_valid=1 and flush=0: latch pc. On hit, drive inst_ready=1 and inst=data next cycle, then go to HOLD. On miss, go to REFILL with word counter cnt=0, mem_req=1, mem_addr={tag,index,cnt,2'b00}.
- REFILL: on mem_done, write mem_data into data[index][cnt]. Capture it as the reply if cnt == requested offset. Increment cnt and update mem_addr in the same edge; mem_req stays high. On the mem_done with cnt=LINE_WORDS-1: set valid and tag, drop mem_req, go to RESPOND.
- RESPOND: drive inst_ready=1 with the captured word for one cycle, then go to HOLD.
- HOLD: one cycle with pc_valid ignored, because fetch drops the request one cycle after seeing ready. Then go to IDLE.
- Flush in IDLE or RESPOND, or on the edge a hit would be reported: no inst_ready; go to IDLE.
- Flush in REFILL: the refill runs to completion, because the memory handshake cannot be aborted, and the line is installed. Set a drop flag; at the end of the refill go to IDLE with no inst_ready.
- rdy=0: every register holds, mem_done is ignored, outputs keep their values.
- Reset: all valid bits 0, state IDLE, inst_ready=0, inst=0, mem_req=0, mem_addr=0, cnt=0, drop flag 0. Reset mid-refill abandons the refill; the line stays invalid.
- The data array needs no reset.
- No writes from the core; self-modifying code is unsupported.

## Timing
- Hit: pc_valid sampled at edge N; inst_ready=1 during cycle N+1 only.
- Miss: mem_req rises at N+1. Line complete on the 4th mem_done at edge M. inst_ready=1 during cycle M+1.
- Back-to-back mem_done on consecutive cycles is legal. The address for word k+1 is presented in the cycle after word k's mem_done.
- Minimum spacing between accepted requests is 2 cycles, due to HOLD.
- Flush and pc_valid high in the same cycle: flush wins, request not accepted.
- cnt wraps 3→0 only at line completion.
- The line fill always starts at word 0; critical-word-first is not used.

## Test plan
- Reset with rst=0 for 2 cycles: inst_ready=0, mem_req=0, mem_addr=0. Then pc_valid with pc=0x0 misses, and mem_req rises with mem_addr=0x0.
- Cold miss at pc=0x1008: memory returns 0xA0,0xA1,0xA2,0xA3 for 0x1000–0x100C, one cycle each. Addresses issued in order; inst_ready pulses with inst=0xA2 one cycle after the 4th mem_done.
- Then request pc=0x100C: hit, inst_ready the next cycle with inst=0xA3 and no mem_req. Then request pc=0x2000: miss.
- Conflict: fill 0x0000, then access 0x0400 (same index, INDEX_BITS=6). Expect a refill. Re-access 0x0000: it misses again.
- Flush asserted during the 2nd refill word: the refill finishes (4 mem_done), no inst_ready. A following request to the same line hits in 1 cycle.
- rdy=0 for 3 cycles mid-refill while mem_done pulses are presented: no state change, cnt unchanged. Once rdy=1, the refill resumes and completes correctly.
